// File: rtl/btn_cond_if.sv
// Button-conditioner signal bundle: raw pins and move strobe in, conditioned
// level / pulse / frame flags out. The master drives the pins, the slave conditions them.
interface btn_cond_if #(
  parameter int NBTN = 5
);
  logic [NBTN-1:0] btn_in;
  logic            move;
  logic [NBTN-1:0] btn_level;
  logic [NBTN-1:0] btn_pulse;
  logic [NBTN-1:0] btn_frame;

  modport master (
    output btn_in, move,
    input  btn_level, btn_pulse, btn_frame
  );

  modport slave (
    input  btn_in, move,
    output btn_level, btn_pulse, btn_frame
  );
endinterface

// File: rtl/btn_cond.sv
// Per-button synchronizer, counter debouncer, rising-edge pulse and a press flag
// latched once per frame on the leading edge of the move strobe.
module btn_cond #(
  parameter int NBTN            = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  btn_cond_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NBTN-1:0]            s1_q, s1_d;
  logic [NBTN-1:0]            s2_q, s2_d;
  logic [NBTN-1:0]            db_q, db_d;
  logic [NBTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NBTN-1:0]            pulse_q, pulse_d;
  logic [NBTN-1:0]            pend_q, pend_d;
  logic [NBTN-1:0]            frame_q, frame_d;
  logic                       move_q, move_d;

  logic [NBTN-1:0]            rise;
  logic                       fstb;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    s1_d   = bus.btn_in;
    s2_d   = s1_q;
    db_d   = db_q;
    cnt_d  = '0;
    rise   = '0;
    move_d = bus.move;
    fstb   = bus.move & ~move_q;

    for (int i = 0; i < NBTN; i++) begin
      // A sample agreeing with the debounced state leaves cnt at 0, which is
      // what restarts the count after any bounce.
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = s2_q[i];
          rise[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    pulse_d = rise;

    // A rise coinciding with the strobe goes straight into this frame's flag.
    if (fstb) begin
      frame_d = pend_q | rise;
      pend_d  = '0;
    end else begin
      frame_d = frame_q;
      pend_d  = pend_q | rise;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      db_q    <= '0;
      // NOTE: the counters are cleared too; a press held through reset must
      // restart a full debounce interval from zero.
      cnt_q   <= '0;
      pulse_q <= '0;
      pend_q  <= '0;
      frame_q <= '0;
      move_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      pend_q  <= pend_d;
      frame_q <= frame_d;
      move_q  <= move_d;
    end
  end

  assign bus.btn_level = db_q;
  assign bus.btn_pulse = pulse_q;
  assign bus.btn_frame = frame_q;

endmodule
